// File: rtl/lsu_byte_sequencer_pkg.sv
// Shared definitions for the load/store byte sequencer: access-size codes,
// FSM encoding and the size / extension helpers used by the LSU and writeback.
package lsu_pkg;

  localparam logic [2:0] CTRL_B  = 3'b000;
  localparam logic [2:0] CTRL_H  = 3'b001;
  localparam logic [2:0] CTRL_W  = 3'b010;
  localparam logic [2:0] CTRL_BU = 3'b100;
  localparam logic [2:0] CTRL_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Zero for codes that do not name an access size.
  function automatic logic [2:0] byte_count(input logic [2:0] ctrl);
    case (ctrl)
      CTRL_B, CTRL_BU: byte_count = 3'd1;
      CTRL_H, CTRL_HU: byte_count = 3'd2;
      CTRL_W:          byte_count = 3'd4;
      default:         byte_count = 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] ctrl, input logic [31:0] raw);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    sb = signed'(raw[7:0]);
    sh = signed'(raw[15:0]);
    case (ctrl)
      CTRL_B:  extend = 32'(sb);
      CTRL_H:  extend = 32'(sh);
      CTRL_BU: extend = {24'd0, raw[7:0]};
      CTRL_HU: extend = {16'd0, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_sequencer_if.sv
// Core-side request/response and byte-wide memory port of the LSU sequencer.
// The sequencer is the master of the memory port and the responder to the core.
interface lsu_byte_sequencer_if;
  logic        lsu_req;
  logic        lsu_we;
  logic [2:0]  lsu_ctrl;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_busy;
  logic        lsu_done;
  logic        lsu_err;
  logic [31:0] lsu_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  modport master (
    input  lsu_req, lsu_we, lsu_ctrl, lsu_addr, lsu_wdata, mem_rdata, mem_ready,
    output lsu_busy, lsu_done, lsu_err, lsu_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output lsu_req, lsu_we, lsu_ctrl, lsu_addr, lsu_wdata, mem_rdata, mem_ready,
    input  lsu_busy, lsu_done, lsu_err, lsu_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_byte_sequencer_load_extend.sv
// Combinational sign/zero extension of assembled load bytes; shared with the
// writeback mux so both paths agree on the size codes.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  ctrl,
  input  logic [31:0] raw,
  output logic [31:0] data
);
  assign data = extend(ctrl, raw);
endmodule

// File: rtl/lsu_byte_sequencer.sv
// Splits a core load/store into little-endian byte transactions on a handshaked
// byte port, with wait-state timeout, and returns the extended load result.
module lsu_byte_sequencer
  import lsu_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1,
  parameter int MAX_WAIT    = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  lsu_byte_sequencer_if.master bus
);
  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  state_t            state;
  logic [1:0]        idx;
  logic [1:0]        idx_nxt;
  logic [1:0]        last_idx;
  logic [WAIT_W-1:0] wcnt;
  logic              l_we;
  logic [2:0]        l_ctrl;
  logic [31:0]       l_addr;
  logic [31:0]       l_wdata;
  logic [31:0]       asm_q;
  logic [31:0]       asm_nxt;
  logic [31:0]       ext_data;
  logic              illegal;
  logic              last_byte;
  logic              timeout;

  always_comb begin
    illegal = 1'b0;
    case (bus.lsu_ctrl)
      CTRL_B:  illegal = 1'b0;
      CTRL_H:  illegal = ALIGN_CHECK && bus.lsu_addr[0];
      CTRL_W:  illegal = ALIGN_CHECK && (bus.lsu_addr[1:0] != 2'b00);
      CTRL_BU: illegal = bus.lsu_we;
      CTRL_HU: illegal = bus.lsu_we || (ALIGN_CHECK && bus.lsu_addr[0]);
      default: illegal = 1'b1;
    endcase
  end

  assign idx_nxt   = idx + 2'd1;
  assign last_byte = (idx == last_idx);
  assign timeout   = (MAX_WAIT != 0) && (32'(wcnt) == 32'(MAX_WAIT - 1));

  // The final byte is merged combinationally so the result registers on the same edge.
  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[{idx, 3'b000} +: 8] = bus.mem_rdata;
  end

  lsu_load_extend u_extend (
    .ctrl (l_ctrl),
    .raw  (asm_nxt),
    .data (ext_data)
  );

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && bus.lsu_req) begin
      l_we     <= bus.lsu_we;
      l_ctrl   <= bus.lsu_ctrl;
      l_addr   <= bus.lsu_addr;
      l_wdata  <= bus.lsu_wdata;
      last_idx <= 2'(byte_count(bus.lsu_ctrl) - 3'd1);
      asm_q    <= '0;
    end else if (state == ST_ACCESS && bus.mem_ready) begin
      asm_q <= asm_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      idx           <= '0;
      wcnt          <= '0;
      bus.lsu_busy  <= 1'b0;
      bus.lsu_done  <= 1'b0;
      bus.lsu_err   <= 1'b0;
      bus.lsu_rdata <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.lsu_done <= 1'b0;
          bus.lsu_err  <= 1'b0;
          if (bus.lsu_req) begin
            idx          <= '0;
            wcnt         <= '0;
            bus.lsu_busy <= 1'b1;
            if (illegal) begin
              state         <= ST_DONE;
              bus.lsu_done  <= 1'b1;
              bus.lsu_err   <= 1'b1;
              bus.lsu_rdata <= '0;
            end else begin
              state         <= ST_ACCESS;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= bus.lsu_we;
              bus.mem_addr  <= bus.lsu_addr;
              bus.mem_wdata <= bus.lsu_wdata[7:0];
            end
          end
        end
        ST_ACCESS: begin
          if (bus.mem_ready) begin
            idx  <= idx_nxt;
            wcnt <= '0;
            if (last_byte) begin
              state        <= ST_DONE;
              bus.mem_req  <= 1'b0;
              bus.mem_we   <= 1'b0;
              bus.lsu_done <= 1'b1;
              bus.lsu_err  <= 1'b0;
              if (!l_we) bus.lsu_rdata <= ext_data;
            end else begin
              bus.mem_addr  <= l_addr + 32'(idx_nxt);
              bus.mem_wdata <= l_wdata[{idx_nxt, 3'b000} +: 8];
            end
          end else if (timeout) begin
            // Bytes already written stay written; only the result is discarded.
            state         <= ST_DONE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.lsu_done  <= 1'b1;
            bus.lsu_err   <= 1'b1;
            bus.lsu_rdata <= '0;
          end else begin
            wcnt <= wcnt + WAIT_W'(1);
          end
        end
        ST_DONE: begin
          state        <= ST_IDLE;
          bus.lsu_busy <= 1'b0;
          bus.lsu_done <= 1'b0;
          bus.lsu_err  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Directed bench for lsu_byte_sequencer: a timeline model of each access is
// checked every cycle, plus literal expectations for the key scenarios.
module tb_lsu_byte_sequencer;
  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_byte_sequencer_if bus ();

  lsu_byte_sequencer #(.ALIGN_CHECK(1'b1), .MAX_WAIT(MAXW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] mem [logic [31:0]];

  int rsp_wait  = 0;
  bit rsp_never = 0;
  int pend      = 0;

  bit          tx_on = 0;
  bit          chk_en = 0;
  int          cyc = 0;
  bit          m_legal, m_tmo, m_we, m_err;
  int          m_n, m_w, m_done_at;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [31:0] m_last_rdata = '0;
  int          seen_done_at = -1;
  logic        seen_err = 1'b0;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check32({tag, "_busy"},  32'(bus.lsu_busy),  32'd0);
    check32({tag, "_done"},  32'(bus.lsu_done),  32'd0);
    check32({tag, "_err"},   32'(bus.lsu_err),   32'd0);
    check32({tag, "_rdata"}, bus.lsu_rdata,      32'd0);
    check32({tag, "_mreq"},  32'(bus.mem_req),   32'd0);
    check32({tag, "_mwe"},   32'(bus.mem_we),    32'd0);
    check32({tag, "_maddr"}, bus.mem_addr,       32'd0);
    check32({tag, "_mwdat"}, 32'(bus.mem_wdata), 32'd0);
  endtask

  // Memory responder: ready after rsp_wait idle cycles per byte, or never.
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      bus.mem_ready = bus.mem_req && !rsp_never && (pend >= rsp_wait);
      bus.mem_rdata = bus.mem_req ? mem_byte(bus.mem_addr) : 8'h00;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (bus.mem_req && bus.mem_ready) begin
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
        pend = 0;
      end else if (bus.mem_req) begin
        pend++;
      end else begin
        pend = 0;
      end
      if (tx_on) cyc++;
    end
  end

  // Per-cycle comparison against the access timeline.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        bit e_busy, e_done, e_mreq;
        int k;
        logic [31:0] sh;
        e_busy = 0; e_done = 0; e_mreq = 0; k = 0;
        if (tx_on && cyc > 0) begin
          e_busy = (cyc <= m_done_at);
          e_done = (cyc == m_done_at);
          if (m_legal && !m_tmo) begin
            e_mreq = (cyc <= m_n * (m_w + 1));
            k = (cyc - 1) / (m_w + 1);
          end else if (m_legal) begin
            e_mreq = (cyc <= MAXW);
          end
          if (bus.lsu_done === 1'b1 && seen_done_at < 0) begin
            seen_done_at = cyc;
            seen_err = bus.lsu_err;
          end
        end
        check32("busy", 32'(bus.lsu_busy), 32'(e_busy));
        check32("done", 32'(bus.lsu_done), 32'(e_done));
        check32("mem_req", 32'(bus.mem_req), 32'(e_mreq));
        if (e_mreq) begin
          sh = m_wdata >> (8 * k);
          check32("mem_addr", bus.mem_addr, m_addr + 32'(k));
          check32("mem_we", 32'(bus.mem_we), 32'(m_we));
          if (m_we) check32("mem_wdata", 32'(bus.mem_wdata), 32'(sh[7:0]));
        end
        if (e_done) begin
          check32("err", 32'(bus.lsu_err), 32'(m_err));
          check32("rdata", bus.lsu_rdata, m_rdata);
        end
      end
    end
  end

  task automatic start_access(input bit we, input logic [2:0] ctrl, input logic [31:0] addr,
                              input logic [31:0] wdata, input int w, input bit never);
    logic [31:0] raw;
    int v;
    bit ill;
    @(posedge clk);
    case (ctrl)
      3'b000, 3'b100: m_n = 1;
      3'b001, 3'b101: m_n = 2;
      3'b010:         m_n = 4;
      default:        m_n = 0;
    endcase
    ill = (m_n == 0) || (we && ctrl[2]) || (m_n == 2 && addr[0]) || (m_n == 4 && addr[1:0] != 2'b00);
    m_legal = !ill;
    m_tmo   = m_legal && never;
    m_w = w; m_we = we; m_addr = addr; m_wdata = wdata;
    m_err = ill || m_tmo;
    if (ill) m_done_at = 1;
    else if (m_tmo) m_done_at = MAXW + 1;
    else m_done_at = m_n * (w + 1) + 1;
    if (m_err) begin
      m_rdata = '0;
    end else if (we) begin
      m_rdata = m_last_rdata;
    end else begin
      raw = '0;
      for (int i = 0; i < m_n; i++) raw = raw | (32'(mem_byte(addr + 32'(i))) << (8 * i));
      case (ctrl)
        3'b000: begin v = int'(raw[7:0]);  if (v >= 128)   v -= 256;   m_rdata = 32'(v); end
        3'b001: begin v = int'(raw[15:0]); if (v >= 32768) v -= 65536; m_rdata = 32'(v); end
        default: m_rdata = raw;
      endcase
    end
    m_last_rdata = m_rdata;
    rsp_wait = w; rsp_never = never;
    seen_done_at = -1; seen_err = 1'b0;
    @(negedge clk);
    bus.lsu_req = 1'b1; bus.lsu_we = we; bus.lsu_ctrl = ctrl;
    bus.lsu_addr = addr; bus.lsu_wdata = wdata;
    cyc = 0; tx_on = 1;
    @(negedge clk);
    bus.lsu_req = 1'b0;
  endtask

  task automatic do_access(input bit we, input logic [2:0] ctrl, input logic [31:0] addr,
                           input logic [31:0] wdata, input int w, input bit never);
    start_access(we, ctrl, addr, wdata, w, never);
    repeat (m_done_at) @(negedge clk);
    tx_on = 0;
    rsp_never = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.lsu_req = 1'b0; bus.lsu_we = 1'b0; bus.lsu_ctrl = 3'b000;
    bus.lsu_addr = '0; bus.lsu_wdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    chk_en = 1;

    do_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0);
    check32("sw_done_cycle", 32'(seen_done_at), 32'd5);
    check32("mem_100", 32'(mem_byte(32'h100)), 32'hEF);
    check32("mem_101", 32'(mem_byte(32'h101)), 32'hBE);
    check32("mem_102", 32'(mem_byte(32'h102)), 32'hAD);
    check32("mem_103", 32'(mem_byte(32'h103)), 32'hDE);

    do_access(1'b0, 3'b010, 32'h100, 32'h0, 0, 0);
    check32("lw_done_cycle", 32'(seen_done_at), 32'd5);
    check32("lw_rdata", bus.lsu_rdata, 32'hDEADBEEF);
    check32("lw_err", 32'(seen_err), 32'd0);

    do_access(1'b1, 3'b000, 32'h500, 32'h77, 0, 0);
    check32("sb_keeps_rdata", bus.lsu_rdata, 32'hDEADBEEF);

    mem[32'h200] = 8'h80;
    mem[32'h201] = 8'hFF;
    do_access(1'b0, 3'b000, 32'h200, 32'h0, 0, 0);
    check32("lb_rdata", bus.lsu_rdata, 32'hFFFFFF80);
    do_access(1'b0, 3'b100, 32'h200, 32'h0, 0, 0);
    check32("lbu_rdata", bus.lsu_rdata, 32'h00000080);
    do_access(1'b0, 3'b001, 32'h200, 32'h0, 0, 0);
    check32("lh_rdata", bus.lsu_rdata, 32'hFFFFFF80);
    do_access(1'b0, 3'b101, 32'h200, 32'h0, 0, 0);
    check32("lhu_rdata", bus.lsu_rdata, 32'h0000FF80);

    mem[32'h10] = 8'h34;
    mem[32'h11] = 8'h92;
    do_access(1'b0, 3'b001, 32'h10, 32'h0, 3, 0);
    check32("wait_done_cycle", 32'(seen_done_at), 32'd9);
    check32("wait_rdata", bus.lsu_rdata, 32'hFFFF9234);

    do_access(1'b0, 3'b010, 32'h102, 32'h0, 0, 0);
    check32("misalign_err", 32'(seen_err), 32'd1);
    check32("misalign_done_cycle", 32'(seen_done_at), 32'd1);
    check32("misalign_rdata", bus.lsu_rdata, 32'd0);
    do_access(1'b0, 3'b111, 32'h0, 32'h0, 0, 0);
    check32("ctrl111_err", 32'(seen_err), 32'd1);
    do_access(1'b1, 3'b100, 32'h40, 32'h12, 0, 0);
    check32("sbu_err", 32'(seen_err), 32'd1);
    check32("sbu_no_write", 32'(mem.exists(32'h40)), 32'd0);

    do_access(1'b0, 3'b000, 32'h300, 32'h0, 0, 1);
    check32("timeout_done_cycle", 32'(seen_done_at), 32'd5);
    check32("timeout_err", 32'(seen_err), 32'd1);

    start_access(1'b1, 3'b010, 32'h400, 32'h11223344, 0, 0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    chk_en = 0;
    tx_on = 0;
    #1 check_zero("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_last_rdata = '0;
    chk_en = 1;
    repeat (3) @(negedge clk);
    check32("rst_mem_400", 32'(mem_byte(32'h400)), 32'h44);
    check32("rst_mem_401", 32'(mem_byte(32'h401)), 32'h33);
    check32("rst_no_402", 32'(mem.exists(32'h402)), 32'd0);

    do_access(1'b1, 3'b000, 32'hFFFFFFFF, 32'h5A, 0, 0);
    check32("sb_top_done_cycle", 32'(seen_done_at), 32'd2);
    check32("sb_top_mem", 32'(mem_byte(32'hFFFFFFFF)), 32'h5A);
    check32("sb_top_err", 32'(seen_err), 32'd0);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_byte_sequencer.md
Name: lsu_byte_sequencer

Overview:
Load/store initiator between the core's memory stage and the byte-wide data memory port. Accepts one load or store per request using the team's 3-bit access-size code. Splits each access into sequential byte transactions, little-endian, and assembles and sign/zero-extends load data. Turns the single-cycle data path into a handshaked, multi-cycle access that can tolerate wait states.

Parameters:
ALIGN_CHECK, 1, 1 = misaligned half/word access is rejected with an error; 0 = allowed, bytes taken at consecutive addresses.
MAX_WAIT, 16, cycles to wait for mem_ready per byte before aborting with an error; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
lsu_req  in  1  request strobe, sampled in IDLE only
lsu_we  in  1  1 = store, 0 = load
lsu_ctrl  in  3  000 sb/lb, 001 sh/lh, 010 sw/lw, 100 lbu, 101 lhu
lsu_addr  in  32  byte address
lsu_wdata  in  32  store data; low bytes are used
lsu_busy  out  1  high from accept until the done cycle, inclusive
lsu_done  out  1  one-cycle completion pulse
lsu_err  out  1  valid with lsu_done; access failed
lsu_rdata  out  32  load result; held until the next accept
mem_req  out  1  byte transaction request
mem_we  out  1  byte write enable
mem_addr  out  32  byte address
mem_wdata  out  8  byte to write
mem_rdata  in  8  byte read; valid when mem_ready = 1
mem_ready  in  1  completes the current byte transaction

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, byte index 0, wait counter 0. Reset asserted mid-access aborts immediately. No done pulse is produced and no further memory traffic occurs.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - When lsu_req = 1, latch we, ctrl, addr and wdata, and clear the assembly register.
  - Byte count N: 1 for ctrl 000/100, 2 for 001/101, 4 for 010.
  - Illegal request: ctrl 011/110/111, a store with ctrl 100/101, or a misalignment when ALIGN_CHECK = 1 (half with addr[0] = 1; word with addr[1:0] != 0). Go to DONE with err = 1 and issue no mem_req.
  - Otherwise go to ACCESS.
- ACCESS:
  - mem_req = 1, mem_addr = latched addr + idx (mod 2^32), mem_we = latched we, mem_wdata = wdata byte[idx].
  - Outputs are registered and hold stable until mem_ready.
  - When mem_ready = 1: a load stores mem_rdata into byte[idx]; idx increments and the wait counter clears.
  - When mem_ready = 1 on the last byte, go to DONE and drop mem_req in that same transition.
  - No mem_ready: the wait counter increments. If it reaches MAX_WAIT (and MAX_WAIT != 0), go to DONE with err = 1. Bytes already written are not rolled back.
- DONE:
  - lsu_done = 1 for exactly one cycle, and lsu_busy = 1 during it. Then go to IDLE.
  - lsu_req in the DONE cycle is ignored; the earliest next accept is the following cycle.
- Load extension:
  - 000: sign-extend bit 7.
  - 001: sign-extend bit 15.
  - 100/101: zero-extend.
  - 010: 32 bits as assembled.
- Store and error data: a store leaves lsu_rdata unchanged. An error leaves lsu_rdata = 0.
- Latency with mem_ready tied high: accept at cycle 0, byte k issued at cycle k+1, done at cycle N+1. Word load = 5 cycles from the request edge to the done pulse.
- lsu_req while busy is ignored; the requester must hold it until it sees !lsu_busy.

Decomposition:
- Package lsu_pkg:
  - ctrl code constants (CTRL_B = 3'b000, CTRL_H, CTRL_W, CTRL_BU, CTRL_HU)
  - FSM state encoding
  - function byte_count(ctrl)
  - function extend(ctrl, raw32)
- One sub-module, lsu_load_extend: combinational sign/zero extension from the assembled bytes and ctrl. It is reused by the writeback mux.

Test Plan:
- Word store then load: store addr 0x100, wdata 0xDEADBEEF, ctrl 010, mem_ready = 1 -> 4 writes: 0x100 = EF, 0x101 = BE, 0x102 = AD, 0x103 = DE; done at cycle 5. Load back -> lsu_rdata = 0xDEADBEEF, err = 0.
- Extension: memory 0x200 = 0x80, 0x201 = 0xFF.
  - lb 0x200 -> 0xFFFFFF80
  - lbu 0x200 -> 0x00000080
  - lh 0x200 -> 0xFFFFFF80
  - lhu 0x200 -> 0x0000FF80
- Wait states: mem_ready low for 3 cycles on each byte of lh 0x10 -> mem_req/mem_addr/mem_we stable while waiting; done at cycle 9; data correct.
- Errors, each -> done + err = 1, zero mem_req cycles:
  - ALIGN_CHECK = 1, lw 0x102
  - ctrl 111
  - store with ctrl 100
- Timeout: MAX_WAIT = 4, mem_ready never asserted -> err + done on the 5th cycle after accept; mem_req then low.
- Reset mid-access: rst_n low during byte 2 of a word store -> all outputs 0 immediately, no done pulse. After release, a new sb 0xFFFFFFFF with data 0x5A completes normally.
